// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with synchronous load, enable and a runtime upper limit.
// WIDTH-bit unsigned count in [0, max_val]; wraps or saturates at the limits.
module updown_counter_mod #(
    parameter int WIDTH       = 8,
    parameter int SATURATE    = 0,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam bit               SAT_MODE = (SATURATE != 0);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;
    logic             out_of_range;

    assign out_of_range = (count > max_val);

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        sat_nxt   = 1'b0;
        if (load) begin
            count_nxt = (count_in > max_val) ? max_val : count_in;
        end else if (en) begin
            // count can exceed the limit only after max_val was lowered at runtime
            if (out_of_range) begin
                if (up) begin
                    if (SAT_MODE) begin
                        count_nxt = max_val;
                        sat_nxt   = 1'b1;
                    end else begin
                        count_nxt = ZERO;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    count_nxt = max_val;
                end
            end else if (up) begin
                if (count != max_val) begin
                    count_nxt = count + ONE;
                end else if (SAT_MODE) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = ZERO;
                    wrap_nxt  = 1'b1;
                end
            end else begin
                if (count != ZERO) begin
                    count_nxt = count - ONE;
                end else if (SAT_MODE) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = max_val;
                    wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
            sat   <= sat_nxt;
        end
    end

    assign at_zero = (count == ZERO);
    assign at_max  = (count == max_val);

endmodule
